// File: rtl/reglk_pkg.sv
// Shared types and constants for the register-lock bank programmer and its slave.
package reglk_pkg;

  localparam int unsigned NB_REGLK_WORDS = 6;

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrRsp,
    StRdReq,
    StRdRsp,
    StDone
  } reglk_state_e;

  localparam logic [1:0] ErrOk      = 2'd0;
  localparam logic [1:0] ErrBresp   = 2'd1;
  localparam logic [1:0] ErrRead    = 2'd2;
  localparam logic [1:0] ErrTimeout = 2'd3;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

endpackage

// File: rtl/reglk_axil_programmer_if.sv
// AXI4-Lite channel bundle between the reglk programmer (master) and the reglk slave port.
interface reglk_axil_programmer_if #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64
);
  localparam int unsigned StrbW = AXI_DATA_WIDTH / 8;

  logic [AXI_ADDR_WIDTH-1:0] m_awaddr;
  logic                      m_awvalid;
  logic                      m_awready;
  logic [AXI_DATA_WIDTH-1:0] m_wdata;
  logic [StrbW-1:0]          m_wstrb;
  logic                      m_wvalid;
  logic                      m_wready;
  logic [1:0]                m_bresp;
  logic                      m_bvalid;
  logic                      m_bready;
  logic [AXI_ADDR_WIDTH-1:0] m_araddr;
  logic                      m_arvalid;
  logic                      m_arready;
  logic [AXI_DATA_WIDTH-1:0] m_rdata;
  logic [1:0]                m_rresp;
  logic                      m_rvalid;
  logic                      m_rready;

  modport master (
    output m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
    output m_araddr, m_arvalid, m_rready,
    input  m_awready, m_wready, m_bresp, m_bvalid, m_arready, m_rdata, m_rresp, m_rvalid
  );

  modport slave (
    input  m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
    input  m_araddr, m_arvalid, m_rready,
    output m_awready, m_wready, m_bresp, m_bvalid, m_arready, m_rdata, m_rresp, m_rvalid
  );
endinterface

// File: rtl/reglk_axil_programmer.sv
// AXI4-Lite initiator that writes NB_WORDS lock words to the reglk bank and optionally
// reads them back; stops at the first error or phase timeout.
module reglk_axil_programmer
  import reglk_pkg::*;
#(
  parameter int unsigned               AXI_ADDR_WIDTH = 64,
  parameter int unsigned               AXI_DATA_WIDTH = 64,
  parameter int unsigned               NB_WORDS       = NB_REGLK_WORDS,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int unsigned               TIMEOUT_CYC    = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic                        verify_i,
  input  logic [32*NB_WORDS-1:0]      lock_vals_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o,
  output logic [1:0]                  err_code_o,
  output logic [$clog2(NB_WORDS)-1:0] err_idx_o,
  reglk_axil_programmer_if.master     axi
);

  localparam int unsigned         IdxW    = $clog2(NB_WORDS);
  localparam int unsigned         CntW    = $clog2(TIMEOUT_CYC);
  localparam logic [IdxW-1:0]     LastIdx = IdxW'(NB_WORDS - 1);
  localparam logic [CntW-1:0]     CntLast = CntW'(TIMEOUT_CYC - 1);
  localparam int unsigned         StrbW   = AXI_DATA_WIDTH / 8;

  reglk_state_e                  state_q;
  logic [CntW-1:0]               cnt_q;
  logic [IdxW-1:0]               idx_q, idx_next;
  logic                          verify_q;
  logic [NB_WORDS-1:0][31:0]     vals_q;
  logic                          awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic [AXI_ADDR_WIDTH-1:0]     awaddr_q, araddr_q;
  logic [AXI_DATA_WIDTH-1:0]     wdata_q;
  logic                          busy_q, done_q, err_q;
  logic [1:0]                    err_code_q;
  logic [IdxW-1:0]               err_idx_q;
  logic                          phase_done, abort, last;
  logic                          unused_rdata;

  function automatic logic [AXI_ADDR_WIDTH-1:0] word_addr(input logic [IdxW-1:0] idx);
    return BASE_ADDR + (AXI_ADDR_WIDTH'(idx) << 3);
  endfunction

  assign idx_next     = idx_q + IdxW'(1);
  assign last         = (idx_q == LastIdx);
  assign unused_rdata = ^axi.m_rdata;

  // Phase completes when every outstanding handshake of the current state has happened.
  always_comb begin
    phase_done = 1'b0;
    unique case (state_q)
      StWrReq: phase_done = (!awvalid_q || axi.m_awready) && (!wvalid_q || axi.m_wready);
      StWrRsp: phase_done = axi.m_bvalid;
      StRdReq: phase_done = axi.m_arready;
      StRdRsp: phase_done = axi.m_rvalid;
      default: phase_done = 1'b0;
    endcase
  end

  assign abort = (cnt_q == CntLast) && !phase_done &&
                 (state_q inside {StWrReq, StWrRsp, StRdReq, StRdRsp});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      verify_q   <= 1'b0;
      vals_q     <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      awaddr_q   <= '0;
      araddr_q   <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ErrOk;
      err_idx_q  <= '0;
    end else begin
      done_q <= 1'b0;
      cnt_q  <= cnt_q + CntW'(1);
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (start_i) begin
            state_q    <= StWrReq;
            busy_q     <= 1'b1;
            verify_q   <= verify_i;
            vals_q     <= lock_vals_i;
            err_q      <= 1'b0;
            err_code_q <= ErrOk;
            err_idx_q  <= '0;
            idx_q      <= '0;
            awvalid_q  <= 1'b1;
            wvalid_q   <= 1'b1;
            awaddr_q   <= word_addr('0);
            wdata_q    <= AXI_DATA_WIDTH'(lock_vals_i[31:0]);
          end
        end
        StWrReq: begin
          if (axi.m_awready) awvalid_q <= 1'b0;
          if (axi.m_wready)  wvalid_q  <= 1'b0;
          if (phase_done) begin
            state_q  <= StWrRsp;
            bready_q <= 1'b1;
            cnt_q    <= '0;
          end
        end
        StWrRsp: begin
          if (axi.m_bvalid) begin
            bready_q <= 1'b0;
            cnt_q    <= '0;
            if (axi.m_bresp != RespOkay) begin
              state_q    <= StDone;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              err_q      <= 1'b1;
              err_code_q <= ErrBresp;
              err_idx_q  <= idx_q;
            end else if (last && verify_q) begin
              state_q   <= StRdReq;
              idx_q     <= '0;
              arvalid_q <= 1'b1;
              araddr_q  <= word_addr('0);
            end else if (last) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q   <= StWrReq;
              idx_q     <= idx_next;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              awaddr_q  <= word_addr(idx_next);
              wdata_q   <= AXI_DATA_WIDTH'(vals_q[idx_next]);
            end
          end
        end
        StRdReq: begin
          if (axi.m_arready) begin
            state_q   <= StRdRsp;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            cnt_q     <= '0;
          end
        end
        StRdRsp: begin
          if (axi.m_rvalid) begin
            rready_q <= 1'b0;
            cnt_q    <= '0;
            if (axi.m_rresp != RespOkay || axi.m_rdata[31:0] != vals_q[idx_q]) begin
              state_q    <= StDone;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              err_q      <= 1'b1;
              err_code_q <= ErrRead;
              err_idx_q  <= idx_q;
            end else if (last) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q   <= StRdReq;
              idx_q     <= idx_next;
              arvalid_q <= 1'b1;
              araddr_q  <= word_addr(idx_next);
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
        default: state_q <= StIdle;
      endcase

      // Timeout overrides whatever the phase logic scheduled above.
      if (abort) begin
        state_q    <= StDone;
        cnt_q      <= '0;
        busy_q     <= 1'b0;
        done_q     <= 1'b1;
        err_q      <= 1'b1;
        err_code_q <= ErrTimeout;
        err_idx_q  <= idx_q;
        awvalid_q  <= 1'b0;
        wvalid_q   <= 1'b0;
        bready_q   <= 1'b0;
        arvalid_q  <= 1'b0;
        rready_q   <= 1'b0;
      end
    end
  end

  assign axi.m_awaddr  = awaddr_q;
  assign axi.m_awvalid = awvalid_q;
  assign axi.m_wdata   = wdata_q;
  assign axi.m_wstrb   = StrbW'(4'hF);
  assign axi.m_wvalid  = wvalid_q;
  assign axi.m_bready  = bready_q;
  assign axi.m_araddr  = araddr_q;
  assign axi.m_arvalid = arvalid_q;
  assign axi.m_rready  = rready_q;

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign err_code_o = err_code_q;
  assign err_idx_o  = err_idx_q;

endmodule

// File: tb/tb_reglk_axil_programmer.sv
// Directed bench for reglk_axil_programmer with a configurable AXI4-Lite slave model.
module tb_reglk_axil_programmer;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         start_i, verify_i;
  logic [191:0] lock_vals_i;
  logic         busy_o, done_o, err_o;
  logic [1:0]   err_code_o;
  logic [2:0]   err_idx_o;

  int n_tests = 0;
  int n_fail  = 0;

  reglk_axil_programmer_if #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64)) axi ();

  reglk_axil_programmer #(.TIMEOUT_CYC(16)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .verify_i    (verify_i),
    .lock_vals_i (lock_vals_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .err_code_o  (err_code_o),
    .err_idx_o   (err_idx_o),
    .axi         (axi)
  );

  always #5 clk_i = ~clk_i;

  // Slave model: drives at negedge, commits handshakes predicted for the posedge in between.
  logic [63:0] aw_log [16];
  logic [63:0] w_log  [16];
  logic [63:0] ar_log [16];
  int n_aw, n_w, n_b, n_ar, n_r;
  int aw_delay, w_delay, b_bad, r_bad;
  bit never_b;
  int stab_err, strb_err;
  bit aw_f, w_f, b_f, ar_f, r_f, aw_pend, w_pend;
  logic [63:0] aw_a, w_d, ar_a, aw_hold, w_hold;
  logic [7:0] w_s;
  int aw_wait, w_wait, ridx;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      {aw_f, w_f, b_f, ar_f, r_f, aw_pend, w_pend} = '0;
      aw_wait = 0;
      w_wait  = 0;
      axi.m_awready = 1'b0; axi.m_wready = 1'b0; axi.m_bvalid = 1'b0;
      axi.m_arready = 1'b0; axi.m_rvalid = 1'b0;
    end else begin
      if (aw_f && n_aw < 16) begin aw_log[n_aw] = aw_a; n_aw++; end
      if (w_f && n_w < 16) begin
        w_log[n_w] = w_d; n_w++;
        if (w_s != 8'h0F) strb_err++;
      end
      if (b_f) begin axi.m_bvalid = 1'b0; n_b++; end
      if (ar_f && n_ar < 16) begin ar_log[n_ar] = ar_a; n_ar++; end
      if (r_f) begin axi.m_rvalid = 1'b0; n_r++; end
      if (aw_pend && (!axi.m_awvalid || axi.m_awaddr != aw_hold)) stab_err++;
      if (w_pend && (!axi.m_wvalid || axi.m_wdata != w_hold)) stab_err++;
      if (!never_b && !axi.m_bvalid && n_aw > n_b && n_w > n_b) begin
        axi.m_bvalid = 1'b1;
        axi.m_bresp  = (int'(aw_log[n_b] >> 3) == b_bad) ? 2'b10 : 2'b00;
      end
      if (!axi.m_rvalid && n_ar > n_r) begin
        ridx = int'(ar_log[n_r] >> 3);
        axi.m_rvalid = 1'b1;
        axi.m_rresp  = 2'b00;
        axi.m_rdata  = {32'hFFFF_FFFF, (ridx == r_bad || ridx >= 16) ? 32'h0 : w_log[ridx][31:0]};
      end
      axi.m_awready = axi.m_awvalid && (aw_wait >= aw_delay);
      aw_wait = (axi.m_awvalid && !axi.m_awready) ? aw_wait + 1 : 0;
      axi.m_wready = axi.m_wvalid && (w_wait >= w_delay);
      w_wait = (axi.m_wvalid && !axi.m_wready) ? w_wait + 1 : 0;
      axi.m_arready = axi.m_arvalid;
      aw_f = axi.m_awvalid && axi.m_awready;  aw_a = axi.m_awaddr;
      w_f  = axi.m_wvalid && axi.m_wready;    w_d  = axi.m_wdata;  w_s = axi.m_wstrb;
      b_f  = axi.m_bvalid && axi.m_bready;
      ar_f = axi.m_arvalid && axi.m_arready;  ar_a = axi.m_araddr;
      r_f  = axi.m_rvalid && axi.m_rready;
      aw_pend = axi.m_awvalid && !axi.m_awready;  aw_hold = axi.m_awaddr;
      w_pend  = axi.m_wvalid && !axi.m_wready;    w_hold  = axi.m_wdata;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic cfg(input int aw_d, input int w_d_, input int bb, input int rb, input bit nb);
    @(negedge clk_i);
    #1;
    aw_delay = aw_d; w_delay = w_d_; b_bad = bb; r_bad = rb; never_b = nb;
    n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0; stab_err = 0; strb_err = 0;
  endtask

  task automatic start_seq(input logic v, input logic [191:0] vals);
    @(negedge clk_i);
    start_i = 1'b1; verify_i = v; lock_vals_i = vals;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  // Counts posedges since the one that accepted start; bounded.
  task automatic wait_done(input int restart_at, output int cyc);
    cyc = 1;
    while (!done_o && cyc < 200) begin
      start_i = (cyc == restart_at);
      if (cyc == restart_at) lock_vals_i = {6{32'hAAAA_5555}};
      @(negedge clk_i);
      cyc++;
    end
    start_i = 1'b0;
    if (!done_o) check("done_seen", done_o, 1);
  endtask

  task automatic check_writes(input string tag, input int n, input logic [191:0] vals);
    check({tag, "_naw"}, n_aw, n);
    check({tag, "_nw"}, n_w, n);
    for (int i = 0; i < n && i < 6; i++) begin
      check({tag, "_awaddr"}, aw_log[i], 64'(8 * i));
      check({tag, "_wdata"}, w_log[i], {32'h0, vals[32*i +: 32]});
    end
    check({tag, "_strb"}, strb_err, 0);
    check({tag, "_stable"}, stab_err, 0);
  endtask

  logic [191:0] v1;
  int cyc;

  initial begin
    v1 = {32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1};
    rst_ni = 1'b0; start_i = 1'b0; verify_i = 1'b0; lock_vals_i = '0;
    axi.m_awready = 1'b0; axi.m_wready = 1'b0; axi.m_bvalid = 1'b0; axi.m_bresp = 2'b00;
    axi.m_arready = 1'b0; axi.m_rvalid = 1'b0; axi.m_rdata = '0; axi.m_rresp = 2'b00;
    aw_delay = 0; w_delay = 0; b_bad = -1; r_bad = -1; never_b = 0;
    repeat (3) @(negedge clk_i);
    #1;
    check("rst_status", {busy_o, done_o, err_o, err_code_o, err_idx_o}, '0);
    check("rst_valids", {axi.m_awvalid, axi.m_wvalid, axi.m_bready, axi.m_arvalid,
                         axi.m_rready}, '0);
    check("rst_awaddr", axi.m_awaddr, '0);
    check("rst_araddr", axi.m_araddr, '0);
    check("rst_wdata", axi.m_wdata, '0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Zero-wait write-only run
    cfg(0, 0, -1, -1, 0);
    start_seq(1'b0, v1);
    check("busy_after_start", busy_o, 1);
    wait_done(0, cyc);
    check("zw_done_cyc", cyc, 13);
    check("zw_err", {err_o, err_code_o}, 0);
    check("zw_busy_at_done", busy_o, 0);
    check_writes("zw", 6, v1);
    @(negedge clk_i);
    check("zw_done_pulse", done_o, 0);

    // AW ready 3 cycles before W
    cfg(0, 3, -1, -1, 0);
    start_seq(1'b0, v1);
    wait_done(0, cyc);
    check("awfirst_done_cyc", cyc, 31);
    check_writes("awfirst", 6, v1);

    // W ready 3 cycles before AW
    cfg(3, 0, -1, -1, 0);
    start_seq(1'b0, v1);
    wait_done(0, cyc);
    check("wfirst_err", err_o, 0);
    check_writes("wfirst", 6, v1);

    // SLVERR on word 3
    cfg(0, 0, 3, -1, 0);
    start_seq(1'b0, v1);
    wait_done(0, cyc);
    check("bresp_code", {err_o, err_code_o}, {1'b1, 2'd1});
    check("bresp_idx", err_idx_o, 3);
    check_writes("bresp", 4, v1);

    // Verify with word 2 read back as zero
    cfg(0, 0, -1, 2, 0);
    start_seq(1'b1, v1);
    wait_done(0, cyc);
    check("rd_code", {err_o, err_code_o}, {1'b1, 2'd2});
    check("rd_idx", err_idx_o, 2);
    check("rd_nar", n_ar, 3);
    for (int i = 0; i < 3; i++) check("rd_araddr", ar_log[i], 64'(8 * i));
    check("rd_naw", n_aw, 6);

    // Clean verify run
    cfg(0, 0, -1, -1, 0);
    start_seq(1'b1, v1);
    wait_done(0, cyc);
    check("vok_done_cyc", cyc, 25);
    check("vok_err", {err_o, err_code_o}, 0);
    check("vok_nar", n_ar, 6);

    // Slave never responds on B
    cfg(0, 0, -1, -1, 1);
    start_seq(1'b0, v1);
    wait_done(0, cyc);
    check("to_done_cyc", cyc, 18);
    check("to_code", {err_o, err_code_o, err_idx_o}, {1'b1, 2'd3, 3'd0});
    check("to_valids", {axi.m_awvalid, axi.m_wvalid, axi.m_bready}, 0);

    // Start pulsed while busy
    cfg(0, 0, -1, -1, 0);
    start_seq(1'b0, v1);
    wait_done(4, cyc);
    check("restart_done_cyc", cyc, 13);
    check_writes("restart", 6, v1);
    repeat (4) @(negedge clk_i);
    check("restart_idle", busy_o, 0);
    check("restart_naw", n_aw, 6);

    // Reset asserted during WR_REQ, then a fresh sequence
    cfg(0, 0, -1, -1, 0);
    start_seq(1'b0, v1);
    check("pre_rst_valids", {axi.m_awvalid, axi.m_wvalid}, 2'b11);
    #2 rst_ni = 1'b0;
    #1 check("mid_rst_outputs", {axi.m_awvalid, axi.m_wvalid, busy_o}, 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    cfg(0, 0, -1, -1, 0);
    start_seq(1'b0, v1);
    wait_done(0, cyc);
    check("post_rst_done_cyc", cyc, 13);
    check("post_rst_err", err_o, 0);
    check_writes("post_rst", 6, v1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
